// File: rtl/alu_pkg.sv
// Shared decode constants and types for the EX-stage ALU: ALUOp/funct codes,
// the internal ALU control encoding, FSM states and the decoded-op bundle.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDU = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_JAL  = 4'b0110;
    localparam logic [3:0] OP_LUI  = 4'b0111;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // Classic MIPS encodings kept for AND/OR/ADD/SUB/SLT/NOR; the rest fill the gaps.
    typedef enum logic [3:0] {
        CTL_AND  = 4'b0000,
        CTL_OR   = 4'b0001,
        CTL_ADD  = 4'b0010,
        CTL_XOR  = 4'b0011,
        CTL_SLL  = 4'b0100,
        CTL_SRL  = 4'b0101,
        CTL_SUB  = 4'b0110,
        CTL_SLT  = 4'b0111,
        CTL_SLTU = 4'b1000,
        CTL_SRA  = 4'b1001,
        CTL_MD   = 4'b1010,
        CTL_MFHI = 4'b1011,
        CTL_NOR  = 4'b1100,
        CTL_MFLO = 4'b1101,
        CTL_MTHI = 4'b1110,
        CTL_MTLO = 4'b1111
    } alu_ctl_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    typedef struct packed {
        alu_ctl_e ctl;
        logic     ovf_en;
        logic     var_sh;
        logic     jal;
        logic     lui;
        logic     illegal;
        logic     md_div;
        logic     md_signed;
    } dec_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the ID/EX register, the EX unit and EX/MEM.
interface alu_exec_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         ALUOp;
    logic [5:0]         FuncCode;
    logic [SHAMT_W-1:0] Shamt;
    logic [WIDTH-1:0]   OpA;
    logic [WIDTH-1:0]   OpB;
    logic               out_valid;
    logic [WIDTH-1:0]   Result;
    logic               Zero;
    logic               Overflow;
    logic               Illegal;

    modport master (
        output in_valid, ALUOp, FuncCode, Shamt, OpA, OpB,
        input  in_ready, out_valid, Result, Zero, Overflow, Illegal
    );

    modport slave (
        input  in_valid, ALUOp, FuncCode, Shamt, OpA, OpB,
        output in_ready, out_valid, Result, Zero, Overflow, Illegal
    );
endinterface

// File: rtl/md_iter.sv
// Iterative multiply (shift-add) / divide (restoring) on operand magnitudes.
// done is high during the last iteration cycle; hi/lo then hold the final values.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] p, p_step, prod;
    logic [WIDTH-1:0]   b_mag, a_raw, a_mag_in, b_mag_in, quo, rem;
    logic [WIDTH:0]     acc_sum, rem_shift, rem_diff;
    logic [CNT_W-1:0]   cnt;
    logic               busy, div_r, neg_q, neg_r, div0;

    assign a_mag_in = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag_in = (is_signed && b[WIDTH-1]) ? -b : b;
    assign done     = busy && (cnt == CNT_W'(WIDTH - 1));

    // p is {accumulator, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        p_step    = p;
        acc_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_mag} : '0);
        rem_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_mag};
        if (div_r) begin
            if (rem_diff[WIDTH]) p_step = {rem_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
            else                 p_step = {rem_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end else begin
            p_step = {acc_sum, p[WIDTH-1:1]};
        end
        quo  = p_step[WIDTH-1:0];
        rem  = p_step[2*WIDTH-1:WIDTH];
        prod = neg_q ? -p_step : p_step;
        if (div_r) begin
            lo = div0 ? '1    : (neg_q ? -quo : quo);
            hi = div0 ? a_raw : (neg_r ? -rem : rem);
        end else begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p     <= '0;
            b_mag <= '0;
            a_raw <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (start) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            p     <= {{WIDTH{1'b0}}, a_mag_in};
            b_mag <= b_mag_in;
            a_raw <= a;
            cnt   <= '0;
            busy  <= 1'b1;
            div_r <= is_div;
            neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed & a[WIDTH-1];
            div0  <= (b == '0);
        end else if (busy) begin
            p   <= p_step;
            cnt <= cnt + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/FuncCode, registers single-cycle results and
// sequences iterative mul/div into the architectural HI/LO registers.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_unit_if.slave bus
);
    import alu_pkg::*;

    state_e             state;
    dec_t               dec;
    logic [WIDTH-1:0]   hi, lo, md_hi, md_lo;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_res, sum, diff;
    logic [SHAMT_W-1:0] sh;
    logic               alu_ovf, md_start, md_done;

    assign bus.in_ready = (state == S_IDLE);
    assign md_start     = bus.in_valid && bus.in_ready && (dec.ctl == CTL_MD);

    always_comb begin
        dec     = '0;
        dec.ctl = CTL_AND;
        if (bus.ALUOp[3]) begin
            case (bus.FuncCode)
                F_ADD:   begin dec.ctl = CTL_ADD; dec.ovf_en = 1'b1; end
                F_ADDU:  dec.ctl = CTL_ADD;
                F_SUB:   begin dec.ctl = CTL_SUB; dec.ovf_en = 1'b1; end
                F_SUBU:  dec.ctl = CTL_SUB;
                F_AND:   dec.ctl = CTL_AND;
                F_OR:    dec.ctl = CTL_OR;
                F_XOR:   dec.ctl = CTL_XOR;
                F_NOR:   dec.ctl = CTL_NOR;
                F_SLT:   dec.ctl = CTL_SLT;
                F_SLTU:  dec.ctl = CTL_SLTU;
                F_SLL:   dec.ctl = CTL_SLL;
                F_SRL:   dec.ctl = CTL_SRL;
                F_SRA:   dec.ctl = CTL_SRA;
                F_SLLV:  begin dec.ctl = CTL_SLL; dec.var_sh = 1'b1; end
                F_SRLV:  begin dec.ctl = CTL_SRL; dec.var_sh = 1'b1; end
                F_MFHI:  dec.ctl = CTL_MFHI;
                F_MFLO:  dec.ctl = CTL_MFLO;
                F_MTHI:  dec.ctl = CTL_MTHI;
                F_MTLO:  dec.ctl = CTL_MTLO;
                F_MULT:  begin dec.ctl = CTL_MD; dec.md_signed = 1'b1; end
                F_MULTU: dec.ctl = CTL_MD;
                F_DIV:   begin dec.ctl = CTL_MD; dec.md_div = 1'b1; dec.md_signed = 1'b1; end
                F_DIVU:  begin dec.ctl = CTL_MD; dec.md_div = 1'b1; end
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            case (bus.ALUOp)
                OP_ADD:  begin dec.ctl = CTL_ADD; dec.ovf_en = 1'b1; end
                OP_ADDU: dec.ctl = CTL_ADD;
                OP_AND:  dec.ctl = CTL_AND;
                OP_OR:   dec.ctl = CTL_OR;
                OP_XOR:  dec.ctl = CTL_XOR;
                OP_SUB:  dec.ctl = CTL_SUB;
                OP_JAL:  begin dec.ctl = CTL_ADD; dec.jal = 1'b1; end
                OP_LUI:  begin dec.ctl = CTL_SLL; dec.lui = 1'b1; end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // jal reuses the adder with a constant 8; lui reuses the left shifter.
    always_comb begin
        alu_a   = bus.OpA;
        alu_b   = dec.jal ? WIDTH'(8) : bus.OpB;
        sh      = dec.lui ? SHAMT_W'(WIDTH / 2) : (dec.var_sh ? bus.OpA[SHAMT_W-1:0] : bus.Shamt);
        sum     = alu_a + alu_b;
        diff    = alu_a - alu_b;
        alu_ovf = 1'b0;
        alu_res = '0;
        case (dec.ctl)
            CTL_ADD: begin
                alu_res = sum;
                alu_ovf = dec.ovf_en & (alu_a[WIDTH-1] == alu_b[WIDTH-1]) & (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            CTL_SUB: begin
                alu_res = diff;
                alu_ovf = dec.ovf_en & (alu_a[WIDTH-1] != alu_b[WIDTH-1]) & (diff[WIDTH-1] != alu_a[WIDTH-1]);
            end
            CTL_AND:  alu_res = alu_a & alu_b;
            CTL_OR:   alu_res = alu_a | alu_b;
            CTL_XOR:  alu_res = alu_a ^ alu_b;
            CTL_NOR:  alu_res = ~(alu_a | alu_b);
            CTL_SLT:  alu_res = WIDTH'($signed(alu_a) < $signed(alu_b));
            CTL_SLTU: alu_res = WIDTH'(alu_a < alu_b);
            CTL_SLL:  alu_res = alu_b << sh;
            CTL_SRL:  alu_res = alu_b >> sh;
            CTL_SRA:  alu_res = $signed(alu_b) >>> sh;
            CTL_MFHI: alu_res = hi;
            CTL_MFLO: alu_res = lo;
            CTL_MTHI: alu_res = alu_a;
            CTL_MTLO: alu_res = alu_a;
            default:  alu_res = '0;
        endcase
        if (dec.illegal) alu_res = '0;
    end

    md_iter #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (dec.md_div),
        .is_signed (dec.md_signed),
        .a         (bus.OpA),
        .b         (bus.OpB),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.Result   <= '0;
            bus.Zero     <= 1'b0;
            bus.Overflow <= 1'b0;
            bus.Illegal  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    if (dec.ctl == CTL_MD) begin
                        state <= dec.md_div ? S_DIV : S_MUL;
                    end else begin
                        bus.out_valid <= 1'b1;
                        bus.Result    <= alu_res;
                        bus.Zero      <= (alu_res == '0);
                        bus.Overflow  <= alu_ovf;
                        bus.Illegal   <= dec.illegal;
                        if (dec.ctl == CTL_MTHI) hi <= bus.OpA;
                        if (dec.ctl == CTL_MTLO) lo <= bus.OpA;
                    end
                end
                S_MUL, S_DIV: if (md_done) begin
                    state         <= S_DONE;
                    hi            <= md_hi;
                    lo            <= md_lo;
                    bus.out_valid <= 1'b1;
                    bus.Result    <= md_lo;
                    bus.Zero      <= (md_lo == '0);
                    bus.Overflow  <= 1'b0;
                    bus.Illegal   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table plus hand-written
// mul/div, reset-abort and back-to-back sequences, all scored via a queue.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: pops one expectation per out_valid pulse.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: out_valid got 1 required 0");
            end else begin
                e = sb.pop_front();
                check({e.name, "_res"},  bus.Result,   e.res);
                check({e.name, "_zero"}, 32'(bus.Zero),     32'(e.zero));
                check({e.name, "_ovf"},  32'(bus.Overflow), 32'(e.ovf));
                check({e.name, "_ill"},  32'(bus.Illegal),  32'(e.ill));
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic ovf, input logic ill);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check({nm, "_wait_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.ALUOp    = op;
        bus.FuncCode = fn;
        bus.Shamt    = sh;
        bus.OpA      = a;
        bus.OpB      = b;
        sb.push_back('{nm, res, (res == 32'd0), ovf, ill});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Iterative op; optionally keeps a second R-type op presented while busy.
    task automatic md_run(input string nm, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo, input logic hold,
                          input logic [5:0] hold_fn, input logic [31:0] hold_exp);
        int cyc;
        issue(nm, 4'b1000, fn, 5'd0, a, b, exp_lo, 1'b0, 1'b0);
        @(negedge clk);
        cyc = 1;
        check({nm, "_busy"}, 32'(bus.in_ready), 32'd0);
        if (hold) begin
            bus.FuncCode = hold_fn;
            bus.OpA      = 32'h0BAD_0BAD;
            sb.push_back('{{nm, "_held"}, hold_exp, (hold_exp == 32'd0), 1'b0, 1'b0});
        end else begin
            bus.in_valid = 1'b0;
        end
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 20) check({nm, "_busy_mid"}, 32'(bus.in_ready), 32'd0);
        end
        check({nm, "_latency"}, 32'(cyc), 32'd33);
        @(negedge clk);
        check({nm, "_ready_back"}, 32'(bus.in_ready), 32'd1);
        if (hold) @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.ALUOp    = '0;
        bus.FuncCode = '0;
        bus.Shamt    = '0;
        bus.OpA      = '0;
        bus.OpB      = '0;

        vq.push_back('{"add_ovf",  4'h8, 6'b100000, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0});
        vq.push_back('{"addu",     4'h8, 6'b100001, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0});
        vq.push_back('{"beq_sub",  4'h4, 6'b000000, 5'd0,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0});
        vq.push_back('{"sub_ovf",  4'h8, 6'b100010, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0});
        vq.push_back('{"subu",     4'h8, 6'b100011, 5'd0,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0});
        vq.push_back('{"and_r",    4'h8, 6'b100100, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
        vq.push_back('{"or_r",     4'h8, 6'b100101, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
        vq.push_back('{"xor_r",    4'h8, 6'b100110, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
        vq.push_back('{"nor_r",    4'h8, 6'b100111, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0});
        vq.push_back('{"slt",      4'h8, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vq.push_back('{"sltu",     4'h8, 6'b101011, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vq.push_back('{"sll31",    4'h8, 6'b000000, 5'd31, 32'h00000000, 32'h00000001, 32'h80000000, 1'b0, 1'b0});
        vq.push_back('{"srl31",    4'h8, 6'b000010, 5'd31, 32'h00000000, 32'h80000000, 32'h00000001, 1'b0, 1'b0});
        vq.push_back('{"sra4",     4'h8, 6'b000011, 5'd4,  32'h00000000, 32'h80000000, 32'hF8000000, 1'b0, 1'b0});
        vq.push_back('{"sllv",     4'h8, 6'b000100, 5'd9,  32'h00000024, 32'h00000003, 32'h00000030, 1'b0, 1'b0});
        vq.push_back('{"srlv",     4'h8, 6'b000110, 5'd0,  32'h00000008, 32'h00000100, 32'h00000001, 1'b0, 1'b0});
        vq.push_back('{"lui",      4'h7, 6'b000000, 5'd0,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0});
        vq.push_back('{"jal",      4'h6, 6'b000000, 5'd0,  32'h00000400, 32'h12345678, 32'h00000408, 1'b0, 1'b0});
        vq.push_back('{"addi_ovf", 4'h0, 6'b000000, 5'd0,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0});
        vq.push_back('{"addiu",    4'h1, 6'b000000, 5'd0,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0});
        vq.push_back('{"andi",     4'h2, 6'b000000, 5'd0,  32'h0000FFFF, 32'h00FF00FF, 32'h000000FF, 1'b0, 1'b0});
        vq.push_back('{"ori",      4'h3, 6'b000000, 5'd0,  32'h0000FFFF, 32'h00FF00FF, 32'h00FFFFFF, 1'b0, 1'b0});
        vq.push_back('{"xori",     4'h5, 6'b000000, 5'd0,  32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b0, 1'b0});
        vq.push_back('{"illegal",  4'h8, 6'b111111, 5'd0,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.Result,         32'd0);
        check("rst_flags",     {29'd0, bus.Zero, bus.Overflow, bus.Illegal}, 32'd0);

        foreach (vq[i])
            issue(vq[i].name, vq[i].op, vq[i].fn, vq[i].sh, vq[i].a, vq[i].b, vq[i].res, vq[i].ovf, vq[i].ill);
        idle(3);

        // Illegal op must leave HI/LO untouched.
        issue("mthi", 4'h8, 6'b010001, 5'd0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        issue("mtlo", 4'h8, 6'b010011, 5'd0, 32'h5A5A5A5A, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b0);
        issue("ill_hl", 4'h8, 6'b111111, 5'd0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1);
        issue("mfhi_keep", 4'h8, 6'b010000, 5'd0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        issue("mflo_keep", 4'h8, 6'b010010, 5'd0, 32'h0, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b0);
        idle(3);

        // Back-to-back: exactly three consecutive pulses.
        #1 max_run = 0;
        issue("b2b_sra", 4'h8, 6'b000011, 5'd4, 32'h0, 32'h80000000, 32'hF8000000, 1'b0, 1'b0);
        issue("b2b_lui", 4'h7, 6'b000000, 5'd0, 32'h0, 32'h00001234, 32'h12340000, 1'b0, 1'b0);
        issue("b2b_jal", 4'h6, 6'b000000, 5'd0, 32'h00000400, 32'h0, 32'h00000408, 1'b0, 1'b0);
        idle(4);
        check("b2b_run", 32'(max_run), 32'd3);

        md_run("mult_neg", 6'b011000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, 6'b0, 32'h0);
        issue("mult_mfhi", 4'h8, 6'b010000, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        md_run("multu", 6'b011001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, 6'b0, 32'h0);
        issue("multu_mfhi", 4'h8, 6'b010000, 5'd0, 32'h0, 32'h0, 32'h00000001, 1'b0, 1'b0);
        md_run("div_neg", 6'b011010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b1, 6'b010010, 32'hFFFFFFFD);
        issue("div_mfhi", 4'h8, 6'b010000, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        md_run("divu_zero", 6'b011011, 32'h7, 32'h0, 32'hFFFFFFFF, 1'b1, 6'b010000, 32'h00000007);
        md_run("div_minneg1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 6'b0, 32'h0);
        issue("minneg1_mfhi", 4'h8, 6'b010000, 5'd0, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0);
        idle(3);

        // Reset in the middle of a multiply aborts it and clears HI/LO.
        issue("pre_mthi", 4'h8, 6'b010001, 5'd0, 32'h11111111, 32'h0, 32'h11111111, 1'b0, 1'b0);
        issue("pre_mtlo", 4'h8, 6'b010011, 5'd0, 32'h22222222, 32'h0, 32'h22222222, 1'b0, 1'b0);
        issue("abort_mult", 4'h8, 6'b011001, 5'd0, 32'h3, 32'h5, 32'hF, 1'b0, 1'b0);
        idle(10);
        check("abort_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_result",    bus.Result,         32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(40);
        issue("post_mfhi", 4'h8, 6'b010000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        issue("post_mflo", 4'h8, 6'b010010, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
